// File: rtl/data_memory_sync.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_sync
// Brief    : Single-port synchronous RAM with registered 1-cycle read, a
//            reset-started clear sweep and an address-range check.
//            Optional macro MEM_RDW_EN: simultaneous WR+RD performs both
//            (write-first); otherwise the write wins and the read is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_sync #(
    parameter int                 DATA_W   = 4,
    parameter int                 ADDR_W   = 4,
    parameter int                 DEPTH    = 16,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR,
    input  logic              RD,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D_IN,
    output logic [DATA_W-1:0] Q,
    output logic              Q_VALID,
    output logic              BUSY,
    output logic              ERR
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [DATA_W-1:0]   q_q;
    logic                qv_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                w_in_range;
    logic                w_idle;
    logic                w_acc_wr;
    logic                w_acc_rd;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_in_range = ({1'b0, A} < DEPTH_C);
    assign w_idle     = (state_q == S_IDLE);
    assign w_acc_wr   = w_idle & WR;
`ifdef MEM_RDW_EN
    assign w_acc_rd   = w_idle & RD;
`else
    assign w_acc_rd   = w_idle & RD & ~WR;
`endif

    // The sweep and normal writes share the single write port.
    assign w_mem_we   = ~RST & (~w_idle | (w_acc_wr & w_in_range));
    assign w_mem_addr = w_idle ? A    : ptr_q;
    assign w_mem_data = w_idle ? D_IN : INIT_VAL;

    // Out-of-range reads return zero; a same-cycle write is forwarded.
    assign w_rd_data  = !w_in_range ? '0 : (w_acc_wr ? D_IN : mem_q[A]);

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            mem_q[w_mem_addr] <= w_mem_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            qv_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    if (ptr_q == LAST_C) begin
                        state_q <= S_IDLE;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (w_acc_rd) begin
                        q_q  <= w_rd_data;
                        qv_q <= 1'b1;
                    end
                    if ((w_acc_wr | w_acc_rd) & ~w_in_range) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign Q       = q_q;
    assign Q_VALID = qv_q;
    assign BUSY    = (state_q == S_CLEAR);
    assign ERR     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_sync
// Brief    : Self-checking bench; a 16-deep and a 12-deep instance share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_sync;

    localparam logic [3:0] IV = 4'h5;
`ifdef MEM_RDW_EN
    localparam bit RDW = 1'b1;
`else
    localparam bit RDW = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST, WR, RD;
    logic [3:0] A, D_IN;
    logic [3:0] q0, q1;
    logic       qv0, qv1, busy0, busy1, err0, err1;

    int checks = 0;
    int errors = 0;

    data_memory_sync #(.DATA_W(4), .ADDR_W(4), .DEPTH(16), .INIT_VAL(IV)) dut0 (
        .CLK(CLK), .RST(RST), .WR(WR), .RD(RD), .A(A), .D_IN(D_IN),
        .Q(q0), .Q_VALID(qv0), .BUSY(busy0), .ERR(err0)
    );

    data_memory_sync #(.DATA_W(4), .ADDR_W(4), .DEPTH(12), .INIT_VAL(IV)) dut1 (
        .CLK(CLK), .RST(RST), .WR(WR), .RD(RD), .A(A), .D_IN(D_IN),
        .Q(q1), .Q_VALID(qv1), .BUSY(busy1), .ERR(err1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: remaining clear cycles, a plain word array per instance.
    logic [3:0] m_mem [2][16];
    int         m_cnt [2];
    logic [3:0] m_q   [2];
    bit         m_qv  [2];
    bit         m_err [2];
    bit         started = 1'b0;
    int         dep;
    bit         inr;

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            dep      = (k == 0) ? 16 : 12;
            inr      = (int'(A) < dep);
            m_qv[k]  = 1'b0;
            m_err[k] = 1'b0;
            if (RST) begin
                m_cnt[k] = dep;
                m_q[k]   = 4'h0;
            end else if (m_cnt[k] > 0) begin
                m_mem[k][dep - m_cnt[k]] = IV;
                m_cnt[k] = m_cnt[k] - 1;
            end else begin
                if (WR && inr) m_mem[k][A] = D_IN;
                if ((WR || RD) && !inr) m_err[k] = 1'b1;
                if (RD && (!WR || RDW)) begin
                    m_qv[k] = 1'b1;
                    m_q[k]  = !inr ? 4'h0 : m_mem[k][A];
                end
            end
        end
        if (RST) started = 1'b1;
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("q0",    q0,    m_q[0]);
            chk("qv0",   qv0,   m_qv[0]);
            chk("busy0", busy0, m_cnt[0] > 0);
            chk("err0",  err0,  m_err[0]);
            chk("q1",    q1,    m_q[1]);
            chk("qv1",   qv1,   m_qv[1]);
            chk("busy1", busy1, m_cnt[1] > 0);
            chk("err1",  err1,  m_err[1]);
        end
    end

    task automatic op(input bit wr, input bit rd, input logic [3:0] a, input logic [3:0] d);
        WR = wr; RD = rd; A = a; D_IN = d;
        @(posedge CLK);
        #1;
        WR = 1'b0; RD = 1'b0;
    endtask

    task automatic count_busy(input int e0, input int e1, input string nm);
        int c0 = 0;
        int c1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (busy0) c0++;
            if (busy1) c1++;
        end
        chk({nm, "_len16"}, c0, e0);
        chk({nm, "_len12"}, c1, e1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; WR = 1'b0; RD = 1'b0; A = '0; D_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_q",    q0,    4'h0);
        chk("rst_qv",   qv0,   1'b0);
        chk("rst_busy", busy0, 1'b1);
        chk("rst_err",  err0,  1'b0);
        RST = 1'b0;
        count_busy(16, 12, "clear");

        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 4'(i), 4'h0);
            chk("init_rd_q",  q0,  IV);
            chk("init_rd_qv", qv0, 1'b1);
        end
        op(1'b0, 1'b0, 4'h0, 4'h0);
        chk("init_rd_qv_end", qv0, 1'b0);

        op(1'b1, 1'b0, 4'h3, 4'hA);
        chk("wr_qv", qv0, 1'b0);
        op(1'b0, 1'b1, 4'h3, 4'h0);
        chk("rd3_q",  q0,  4'hA);
        chk("rd3_qv", qv0, 1'b1);
        op(1'b0, 1'b0, 4'h0, 4'h0);
        chk("hold_q",  q0,  4'hA);
        chk("hold_qv", qv0, 1'b0);
        op(1'b0, 1'b1, 4'h4, 4'h0);
        chk("rd4_q", q0, IV);

        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 4'(i), 4'(i + 1));
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, 4'(i), 4'h0);
            chk("b2b_q",  q0,  4'(i + 1));
            chk("b2b_qv", qv0, 1'b1);
        end
        op(1'b0, 1'b0, 4'h0, 4'h0);
        chk("b2b_qv_end", qv0, 1'b0);

        op(1'b1, 1'b0, 4'h7, 4'h2);
        op(1'b1, 1'b1, 4'h7, 4'h9);
`ifdef MEM_RDW_EN
        chk("rdw_q",  q0,  4'h9);
        chk("rdw_qv", qv0, 1'b1);
`else
        chk("rdw_q",  q0,  4'h4);
        chk("rdw_qv", qv0, 1'b0);
`endif
        op(1'b0, 1'b1, 4'h7, 4'h0);
        chk("rd7_q", q0, 4'h9);

        op(1'b1, 1'b0, 4'hD, 4'hF);
        chk("oor_wr_err1", err1, 1'b1);
        chk("oor_wr_err0", err0, 1'b0);
        op(1'b0, 1'b1, 4'hD, 4'h0);
        chk("oor_rd_q1",   q1,   4'h0);
        chk("oor_rd_qv1",  qv1,  1'b1);
        chk("oor_rd_err1", err1, 1'b1);
        op(1'b0, 1'b0, 4'h0, 4'h0);
        chk("oor_err1_end", err1, 1'b0);
        op(1'b0, 1'b1, 4'h1, 4'h0);
        chk("oor_mem1_q", q1, 4'h2);

        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        op(1'b0, 1'b0, 4'h0, 4'h0);
        op(1'b0, 1'b0, 4'h0, 4'h0);
        op(1'b1, 1'b0, 4'h2, 4'hF);
        chk("lock_err0", err0, 1'b0);
        op(1'b0, 1'b0, 4'h0, 4'h0);
        op(1'b0, 1'b0, 4'h0, 4'h0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        count_busy(16, 12, "reclear");
        op(1'b0, 1'b1, 4'h2, 4'h0);
        chk("lock_rd2_q0", q0, IV);
        chk("lock_rd2_q1", q1, IV);
        op(1'b0, 1'b0, 4'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
